// File: rtl/data_mem_pkg.sv
// Shared encodings for the handshaked data memory: size codes, error codes,
// FSM states and the response payload.
package data_mem_pkg;

    localparam logic [2:0] SIZE_WORD   = 3'b000;
    localparam logic [2:0] SIZE_BYTE   = 3'b001;
    localparam logic [2:0] SIZE_HALF   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b011;
    localparam logic [2:0] SIZE_HALF_U = 3'b100;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } rsp_t;

    // Access width in bytes; illegal codes fall through to 4 (flagged elsewhere).
    function automatic logic [2:0] size_nbytes(input logic [2:0] size);
        case (size)
            SIZE_BYTE, SIZE_BYTE_U: size_nbytes = 3'd1;
            SIZE_HALF, SIZE_HALF_U: size_nbytes = 3'd2;
            default:                size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bank.sv
// Word-organised storage: byte-strobed synchronous write, combinational read.
module data_memory_bank #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             CLK,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/data_memory_hs.sv
// Valid/ready data memory with fixed response latency, error checking and a
// zero sweep after reset. Big-endian: lowest address is the MSB.
module data_memory_hs
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LATENCY   = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err
);

    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned CNT_W = 3;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rsp_t             pay_q, pay_d, rsp_q, rsp_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             init_done_q, init_done_d;

    logic             accept;
    logic [1:0]       err_c;
    logic [31:0]      ld_data;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [31:0]      rd_word;
    logic [3:0]       bank_strb;
    logic [IDX_W-1:0] bank_widx;
    logic [31:0]      bank_wdata;
    logic [ADDR_W:0]  end_addr;

    assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(size_nbytes(req_size));

    // Error classification in priority order: size, alignment, range.
    always_comb begin
        err_c = ERR_OK;
        if (req_size > SIZE_HALF_U) begin
            err_c = ERR_SIZE;
        end else if ((((req_size == SIZE_HALF) || (req_size == SIZE_HALF_U)) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))) begin
            err_c = ERR_MISALIGN;
        end else if (end_addr > (ADDR_W+1)'(MEM_BYTES)) begin
            err_c = ERR_RANGE;
        end
    end

    // Load lane selection and extension; offset 0 lives in bits [31:24].
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rd_word >> {~req_addr[1:0], 3'b000};
        half    = req_addr[1] ? rd_word[15:0] : rd_word[31:16];
        case (req_size)
            SIZE_BYTE:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            SIZE_BYTE_U: ld_data = {24'h0, shifted[7:0]};
            SIZE_HALF:   ld_data = {{16{half[15]}}, half};
            SIZE_HALF_U: ld_data = {16'h0, half};
            default:     ld_data = rd_word;
        endcase
        if (req_we || (err_c != ERR_OK)) ld_data = '0;
    end

    // Store lane strobes with the data replicated across lanes.
    always_comb begin
        st_strb = 4'b0000;
        st_data = req_wdata;
        case (req_size)
            SIZE_BYTE, SIZE_BYTE_U: begin
                st_strb = 4'b1000 >> req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            SIZE_HALF, SIZE_HALF_U: begin
                st_strb = req_addr[1] ? 4'b0011 : 4'b1100;
                st_data = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: st_strb = 4'b1111;
            default:   st_strb = 4'b0000;
        endcase
    end

    // The zero sweep owns the write port during INIT.
    always_comb begin
        if (state_q == ST_INIT) begin
            bank_strb  = 4'b1111;
            bank_widx  = init_idx_q;
            bank_wdata = '0;
        end else begin
            bank_strb  = (accept && req_we && (err_c == ERR_OK)) ? st_strb : 4'b0000;
            bank_widx  = req_addr[IDX_W+1:2];
            bank_wdata = st_data;
        end
    end

    data_memory_bank #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .CLK   (CLK),
        .wstrb (bank_strb),
        .widx  (bank_widx),
        .wdata (bank_wdata),
        .ridx  (req_addr[IDX_W+1:2]),
        .rdata (rd_word)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        cnt_d       = cnt_q;
        pay_d       = pay_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + IDX_W'(1);
                if (init_idx_q == IDX_W'(WORDS - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    pay_d.rdata = ld_data;
                    pay_d.err   = err_c;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_d       = (state_d == ST_RESP) ? pay_d : '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            cnt_q       <= '0;
            pay_q       <= '0;
            rsp_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            cnt_q       <= cnt_d;
            pay_q       <= pay_d;
            rsp_q       <= rsp_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed steps plus random traffic against a
// byte-array model of the memory.
module tb_data_memory_hs;

    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned LATENCY   = 2;

    logic        CLK;
    logic        RESET_N;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [MEM_BYTES];
    logic [31:0] last_rdata;
    logic [1:0]  last_err;

    data_memory_hs #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (32),
        .LATENCY   (LATENCY)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
    endtask

    // Counts rising edges from reset release until init_done.
    task automatic wait_init(input string tag);
        int   n;
        logic stale;
        n = 0;
        stale = 1'b0;
        while (!init_done && n < 500) begin
            @(posedge CLK);
            n++;
            #1;
            if (rsp_valid) stale = 1'b1;
        end
        check({tag, " init_cycles"}, 32'(n), 32'(MEM_BYTES / 4));
        check({tag, " ready_after_init"}, {31'b0, req_ready}, 32'd1);
        check({tag, " no_stale_rsp"}, {31'b0, stale}, 32'd0);
    endtask

    // One complete transaction: model prediction, handshake, latency, optional stall.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] size, input int hold, input string tag);
        int          n;
        int          nb;
        logic [1:0]  e_err;
        logic [31:0] e_data;
        logic [31:0] acc;
        logic [63:0] last_byte;
        nb = (size == 3'd1 || size == 3'd3) ? 1 : (size == 3'd2 || size == 3'd4) ? 2 : 4;
        last_byte = 64'(addr) + 64'(nb);
        if (size > 3'd4) e_err = 2'b11;
        else if (((size == 3'd2 || size == 3'd4) && (addr % 2 != 0)) ||
                 (size == 3'd0 && (addr % 4 != 0))) e_err = 2'b01;
        else if (last_byte > 64'(MEM_BYTES)) e_err = 2'b10;
        else e_err = 2'b00;
        e_data = 32'h0;
        if (e_err == 2'b00 && !we) begin
            acc = 32'h0;
            for (int i = 0; i < nb; i++) acc = (acc << 8) | 32'(mem_m[addr + 32'(i)]);
            case (size)
                3'd1:    e_data = (acc[7] ? 32'hFFFFFF00 : 32'h0) | acc;
                3'd2:    e_data = (acc[15] ? 32'hFFFF0000 : 32'h0) | acc;
                default: e_data = acc;
            endcase
        end
        if (e_err == 2'b00 && we) begin
            for (int i = 0; i < nb; i++) mem_m[addr + 32'(i)] = 8'(wdata >> (8 * (nb - 1 - i)));
        end

        @(negedge CLK);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'(($urandom % 5));
        n = 1;
        @(negedge CLK);
        while (!rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(LATENCY));
        check({tag, " rdata"}, rsp_rdata, e_data);
        check({tag, " err"}, {30'b0, rsp_err}, {30'b0, e_err});
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h0;
            req_size  = 3'd0;
            req_wdata = 32'hDEADBEEF;
            @(negedge CLK);
            check({tag, " hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, " hold_rdata"}, rsp_rdata, e_data);
            check({tag, " hold_err"}, {30'b0, rsp_err}, {30'b0, e_err});
            check({tag, " hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check({tag, " rsp_done"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " back_idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        RESET_N   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_size  = 3'd0;
        rsp_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge CLK);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", {30'b0, rsp_err}, 32'd0);
        check("rst init_done", {31'b0, init_done}, 32'd0);
        RESET_N = 1'b1;
        wait_init("boot");

        txn(1'b0, 32'h00, 32'h0, 3'd0, 0, "ld_w_0");
        check("ld_w_0 lit", last_rdata, 32'h0);

        txn(1'b1, 32'h10, 32'h11223344, 3'd0, 0, "st_w_10");
        txn(1'b0, 32'h10, 32'h0, 3'd1, 0, "ld_b_10");
        check("ld_b_10 lit", last_rdata, 32'h00000011);
        txn(1'b0, 32'h12, 32'h0, 3'd2, 0, "ld_h_12");
        check("ld_h_12 lit", last_rdata, 32'h00003344);

        txn(1'b1, 32'h21, 32'h00000080, 3'd1, 0, "st_b_21");
        txn(1'b0, 32'h21, 32'h0, 3'd1, 0, "ld_b_21");
        check("ld_b_21 lit", last_rdata, 32'hFFFFFF80);
        txn(1'b0, 32'h21, 32'h0, 3'd3, 0, "ld_bu_21");
        check("ld_bu_21 lit", last_rdata, 32'h00000080);
        txn(1'b0, 32'h20, 32'h0, 3'd4, 0, "ld_hu_20");
        check("ld_hu_20 lit", last_rdata, 32'h00000080);

        txn(1'b1, 32'h31, 32'h0000ABCD, 3'd2, 0, "st_h_31");
        check("st_h_31 lit", {30'b0, last_err}, 32'd1);
        txn(1'b0, 32'h30, 32'h0, 3'd0, 0, "ld_w_30");
        check("ld_w_30 lit", last_rdata, 32'h0);
        txn(1'b0, 32'hFE, 32'h0, 3'd0, 0, "ld_w_fe");
        check("ld_w_fe lit", {30'b0, last_err}, 32'd1);
        txn(1'b0, 32'h100, 32'h0, 3'd0, 0, "ld_w_100");
        check("ld_w_100 lit", {30'b0, last_err}, 32'd2);
        txn(1'b0, 32'h10, 32'h0, 3'd7, 0, "ld_sz7");
        check("ld_sz7 lit", {30'b0, last_err}, 32'd3);
        txn(1'b0, 32'hFFFFFFFC, 32'h0, 3'd0, 0, "ld_w_top");
        check("ld_w_top lit", {30'b0, last_err}, 32'd2);

        txn(1'b0, 32'h10, 32'h0, 3'd0, 3, "stall");
        check("stall lit", last_rdata, 32'h11223344);

        // Reset while a load is waiting for its response.
        @(negedge CLK);
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_size  = 3'd0;
        req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst req_ready", {31'b0, req_ready}, 32'd0);
        check("midrst init_done", {31'b0, init_done}, 32'd0);
        check("midrst rsp_rdata", rsp_rdata, 32'h0);
        clear_model();
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_init("reinit");
        txn(1'b0, 32'h10, 32'h0, 3'd0, 0, "post_rst_ld");
        check("post_rst_ld lit", last_rdata, 32'h0);

        for (int t = 0; t < 80; t++) begin
            logic        we;
            logic [2:0]  size;
            logic [31:0] addr;
            int          sel;
            we   = 1'($urandom % 2);
            size = (($urandom % 10) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            sel  = int'($urandom % 8);
            if (sel < 4) begin
                addr = 32'($urandom_range(0, MEM_BYTES - 1));
                if (size == 3'd0) addr = addr & 32'hFFFFFFFC;
                else if (size == 3'd2 || size == 3'd4) addr = addr & 32'hFFFFFFFE;
            end else if (sel < 6) begin
                addr = 32'($urandom_range(0, MEM_BYTES - 1));
            end else if (sel == 6) begin
                addr = 32'($urandom_range(MEM_BYTES - 6, MEM_BYTES + 7));
            end else begin
                addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            end
            txn(we, addr, $urandom, size, int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
